// File: rtl/j1_uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the J1 UART TX arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the UART engine.
interface j1_uart_tx_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic [1:0]  grant_o;
  logic        active_o;
  logic        drop_o;
  logic        abort_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, tx_start_o, tx_data_o, grant_o, active_o, drop_o, abort_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, tx_start_o, tx_data_o, grant_o, active_o, drop_o, abort_o
  );
endinterface

// File: rtl/j1_uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART TX engine between two byte sources.
// Optional forced release of a stalled packet: define J1_UART_ARB_TIMEOUT_EN.
module j1_uart_tx_arbiter #(
  parameter int BUSY_WAIT_MAX  = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 sys_clk_i,
  input logic                 sys_rst_i,
  j1_uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       last_q, last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] ready;
  logic       win;
  logic       done;
  logic       drop;
  logic       abort;

`ifdef J1_UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  function automatic logic [7:0] sel_byte(input logic [15:0] data, input logic idx);
    return idx ? data[15:8] : data[7:0];
  endfunction

  // A lone requester always wins; a tie goes to the round-robin pointer.
  always_comb begin
    unique case (bus.req_valid_i)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = rr_ptr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    wait_cnt_d = wait_cnt_q;
    ready      = 2'b00;
    done       = 1'b0;
    drop       = 1'b0;
    abort      = 1'b0;
`ifdef J1_UART_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_valid_i) begin
          ready[win] = 1'b1;
          owner_d    = win;
          grant_d    = win ? 2'b10 : 2'b01;
          tx_data_d  = sel_byte(bus.req_data_i, win);
          last_d     = bus.req_last_i[win];
          state_d    = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (bus.tx_busy_i) begin
          state_d = S_WAIT_FALL;
        end else if (wait_cnt_q == 8'(BUSY_WAIT_MAX)) begin
          drop = 1'b1;
          done = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_WAIT_FALL: begin
        done = ~bus.tx_busy_i;
      end
      S_HOLD: begin
        // Packet lock: only the owner can be served until its last byte completes.
        if (bus.req_valid_i[owner_q]) begin
          ready[owner_q] = 1'b1;
          tx_data_d      = sel_byte(bus.req_data_i, owner_q);
          last_d         = bus.req_last_i[owner_q];
          state_d        = S_START;
`ifdef J1_UART_ARB_TIMEOUT_EN
          hold_cnt_d     = '0;
        end else if (hold_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      if (last_q) begin
        grant_d  = 2'b00;
        rr_ptr_d = ~owner_q;
        state_d  = S_IDLE;
      end else begin
        state_d  = S_HOLD;
`ifdef J1_UART_ARB_TIMEOUT_EN
        hold_cnt_d = '0;
`endif
      end
    end

    if (abort) begin
      grant_d  = 2'b00;
      rr_ptr_d = ~owner_q;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      grant_q    <= 2'b00;
      rr_ptr_q   <= 1'b0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'd0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef J1_UART_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
  assign bus.abort_o = abort;
`else
  assign bus.abort_o = 1'b0;
`endif

  // Ready is combinational from valid, so it is masked while reset holds everything quiet.
  assign bus.req_ready_o = ready & {2{sys_rst_i}};
  assign bus.tx_start_o  = (state_q == S_START);
  assign bus.tx_data_o   = tx_data_q;
  assign bus.grant_o     = grant_q;
  assign bus.active_o    = |grant_q;
  assign bus.drop_o      = drop;

endmodule

// File: tb/tb_j1_uart_tx_arbiter.sv
// Bench for j1_uart_tx_arbiter: byte-lifecycle model checked every cycle plus directed literal checks.
module tb_j1_uart_tx_arbiter;
  localparam int BWM = 15;
  localparam int TMO = 8;
`ifdef J1_UART_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  j1_uart_tx_arbiter_if bus_if ();

  j1_uart_tx_arbiter #(
    .BUSY_WAIT_MAX (BWM),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .bus      (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- requesters: {last, byte} queues ----------------
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  initial begin
    logic [1:0]  took;
    logic [1:0]  v;
    logic [15:0] d;
    logic [1:0]  l;
    bus_if.req_valid_i = 2'b00;
    bus_if.req_data_i  = 16'h0;
    bus_if.req_last_i  = 2'b00;
    forever begin
      @(negedge clk);
      took = bus_if.req_ready_o;
      @(posedge clk);
      #1;
      if (took[0] && q0.size() > 0) void'(q0.pop_front());
      if (took[1] && q1.size() > 0) void'(q1.pop_front());
      v = 2'b00; d = 16'h0; l = 2'b00;
      if (q0.size() > 0) begin v[0] = 1'b1; d[7:0]  = q0[0][7:0]; l[0] = q0[0][8]; end
      if (q1.size() > 0) begin v[1] = 1'b1; d[15:8] = q1[0][7:0]; l[1] = q1[0][8]; end
      bus_if.req_valid_i = v;
      bus_if.req_data_i  = d;
      bus_if.req_last_i  = l;
    end
  end

  // ---------------- UART engine stand-in ----------------
  bit uart_on  = 1'b1;
  int busy_len = 10;

  initial begin
    bus_if.tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.tx_start_o && uart_on) begin
        @(posedge clk);
        #1 bus_if.tx_busy_i = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus_if.tx_busy_i = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  int   cyc = 0;
  int   m_lock = -1;      // packet owner, -1 when no packet
  int   m_rr = 0;
  int   m_start = 0;      // cycle in which the current byte's start strobe is due
  int   m_idle = 0;       // consecutive owner-idle cycles between bytes of a packet
  int   m_byte = 0;
  bit   m_inflight = 1'b0;
  bit   m_rise = 1'b0;
  bit   m_last = 1'b0;
  logic prev_busy = 1'b0;
  int   n_abort_total = 0;
  int   rdy_cyc[$], rdy_port[$], st_cyc[$], st_data[$], drop_cyc[$], abort_cyc[$], fall_cyc[$];

  task automatic step_model();
    logic [1:0]  v, e_rdy, e_grant;
    logic [15:0] d;
    logic        busy;
    int          w;
    bit          e_start, e_drop, e_abort, done, rise_now;
    cyc++;
    v    = bus_if.req_valid_i;
    d    = bus_if.req_data_i;
    busy = bus_if.tx_busy_i;
    e_rdy = 2'b00; e_drop = 1'b0; e_abort = 1'b0; done = 1'b0; rise_now = 1'b0; w = 0;

    if (!m_inflight) begin
      if (m_lock < 0) begin
        if (v != 2'b00) begin
          w = (v == 2'b11) ? m_rr : (v[1] ? 1 : 0);
          e_rdy[w] = 1'b1;
        end
      end else if (v[m_lock]) begin
        w = m_lock;
        e_rdy[w] = 1'b1;
      end else if (TMO_EN && (m_idle + 1 == TMO)) begin
        e_abort = 1'b1;
      end
    end else if (cyc > m_start) begin
      if (m_rise) done = !busy;
      else if (busy) rise_now = 1'b1;
      else if (cyc - m_start == BWM + 1) begin
        e_drop = 1'b1;
        done   = 1'b1;
      end
    end
    e_start = m_inflight && (cyc == m_start);
    e_grant = (m_lock < 0) ? 2'b00 : (2'b01 << m_lock);

    chk("ready",    bus_if.req_ready_o, e_rdy);
    chk("tx_start", bus_if.tx_start_o,  e_start);
    chk("grant",    bus_if.grant_o,     e_grant);
    chk("active",   bus_if.active_o,    (m_lock >= 0));
    chk("drop",     bus_if.drop_o,      e_drop);
    chk("abort",    bus_if.abort_o,     e_abort);
    if (m_inflight && cyc >= m_start) chk("tx_data", bus_if.tx_data_o, m_byte);

    if (bus_if.req_ready_o != 2'b00) begin rdy_cyc.push_back(cyc); rdy_port.push_back(bus_if.req_ready_o[1]); end
    if (bus_if.tx_start_o) begin st_cyc.push_back(cyc); st_data.push_back(bus_if.tx_data_o); end
    if (bus_if.drop_o) drop_cyc.push_back(cyc);
    if (bus_if.abort_o) begin abort_cyc.push_back(cyc); n_abort_total++; end
    if (prev_busy && !busy) fall_cyc.push_back(cyc);
    prev_busy = busy;

    if (e_rdy != 2'b00) begin
      m_inflight = 1'b1;
      m_start    = cyc + 1;
      m_rise     = 1'b0;
      m_lock     = w;
      m_idle     = 0;
      m_byte     = (w == 1) ? int'(d[15:8]) : int'(d[7:0]);
      m_last     = bus_if.req_last_i[w];
    end else if (rise_now) begin
      m_rise = 1'b1;
    end else if (done) begin
      m_inflight = 1'b0;
      m_idle     = 0;
      if (m_last) begin
        m_rr   = 1 - m_lock;
        m_lock = -1;
      end
    end else if (e_abort) begin
      m_rr   = 1 - m_lock;
      m_lock = -1;
      m_idle = 0;
    end else if (!m_inflight && m_lock >= 0) begin
      m_idle++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_lock = -1; m_rr = 0; m_inflight = 1'b0; m_rise = 1'b0; m_idle = 0; prev_busy = 1'b0;
      end else begin
        step_model();
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    rdy_cyc.delete(); rdy_port.delete(); st_cyc.delete(); st_data.delete();
    drop_cyc.delete(); abort_cyc.delete(); fall_cyc.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (!(q0.size() == 0 && q1.size() == 0 && !m_inflight && m_lock < 0 && !bus_if.tx_busy_i) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) expire(name);
    @(negedge clk); #1;
  endtask

  task automatic wait_busy(input string name, input logic level, input int budget);
    int k;
    k = 0;
    while (bus_if.tx_busy_i !== level && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) expire(name);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"},  bus_if.req_ready_o, 0);
    chk({tag, "_start"},  bus_if.tx_start_o,  0);
    chk({tag, "_data"},   bus_if.tx_data_o,   0);
    chk({tag, "_grant"},  bus_if.grant_o,     0);
    chk({tag, "_active"}, bus_if.active_o,    0);
    chk({tag, "_drop"},   bus_if.drop_o,      0);
    chk({tag, "_abort"},  bus_if.abort_o,     0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic int qv(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int exp_tie[6];
    int exp_lock[4];
    exp_tie  = '{'h30, 'h31, 'h30, 'h31, 'h30, 'h31};
    exp_lock = '{'hA0, 'hA1, 'hA2, 'h5B};

    repeat (3) @(negedge clk);
    #1 check_quiet("reset");
    #1 rst_n = 1'b1;

    // single byte from req0
    clear_logs();
    q0.push_back({1'b1, 8'h41});
    wait_idle("single_idle", 200);
    chk("single_nstart", st_data.size(), 1);
    chk("single_port",   qv(rdy_port, 0), 0);
    chk("single_lat",    qv(st_cyc, 0) - qv(rdy_cyc, 0), 1);
    chk("single_data",   qv(st_data, 0), 'h41);
    chk("single_grant",  bus_if.grant_o, 0);
    chk("single_active", bus_if.active_o, 0);

    // ties alternate starting from req0 after reset
    pulse_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'h30});
      q1.push_back({1'b1, 8'h31});
    end
    wait_idle("tie_idle", 400);
    chk("tie_nstart", st_data.size(), 6);
    for (int i = 0; i < 6; i++) chk("tie_order", qv(st_data, i), exp_tie[i]);

    // packet lock: req1 waits for the whole req0 packet
    clear_logs();
    q0.push_back({1'b0, 8'hA0});
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'h5B});
    wait_idle("lock_idle", 400);
    chk("lock_nstart", st_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("lock_order", qv(st_data, i), exp_lock[i]);
    for (int i = 0; i < 4; i++) chk("lock_port", qv(rdy_port, i), (i == 3) ? 1 : 0);
    chk("lock_fall_to_ready", qv(rdy_cyc, 1) - qv(fall_cyc, 0), 1);
    chk("lock_req1_after",    qv(rdy_cyc, 3) - qv(fall_cyc, 2), 1);

    // busy never rises: drop 16 cycles after start
    uart_on = 1'b0;
    clear_logs();
    q0.push_back({1'b1, 8'h55});
    wait_idle("drop_idle", 100);
    chk("drop_count",  drop_cyc.size(), 1);
    chk("drop_delay",  qv(drop_cyc, 0) - qv(st_cyc, 0), 16);
    chk("drop_grant",  bus_if.grant_o, 0);
    clear_logs();
    q1.push_back({1'b0, 8'h60});
    q1.push_back({1'b1, 8'h61});
    wait_idle("drop2_idle", 200);
    chk("drop2_count", drop_cyc.size(), 2);
    chk("drop2_b0",    qv(st_data, 0), 'h60);
    chk("drop2_b1",    qv(st_data, 1), 'h61);
    uart_on = 1'b1;

    // reset while waiting for busy to fall
    clear_logs();
    q0.push_back({1'b1, 8'h77});
    wait_busy("rst_busy_hi", 1'b1, 50);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet("midrst");
    wait_busy("rst_busy_lo", 1'b0, 50);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    q1.push_back({1'b1, 8'h66});
    wait_idle("rst_idle", 200);
    chk("rst_port", qv(rdy_port, 0), 1);
    chk("rst_data", qv(st_data, 0), 'h66);

`ifdef J1_UART_ARB_TIMEOUT_EN
    // stalled packet is force-released and the waiting requester served next
    clear_logs();
    q0.push_back({1'b0, 8'hA0});
    q1.push_back({1'b1, 8'hB1});
    wait_idle("tmo_idle", 300);
    chk("tmo_count",       abort_cyc.size(), 1);
    chk("tmo_delay",       qv(abort_cyc, 0) - qv(fall_cyc, 0), 8);
    chk("tmo_next_ready",  qv(rdy_cyc, 1) - qv(abort_cyc, 0), 1);
    chk("tmo_next_port",   qv(rdy_port, 1), 1);
    chk("tmo_next_data",   qv(st_data, 1), 'hB1);
`else
    chk("abort_never", n_abort_total, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/j1_uart_tx_arbiter.md
Name: j1_uart_tx_arbiter

Overview:
Shares the single SoC UART transmitter (uart_tx path) between two byte sources: port 0 is the J1 CPU I/O write path and port 1 is the debug/LED status source. It grants the transmitter round-robin and holds the grant for the length of a multi-byte packet. It sequences each byte as capture, start pulse, busy rise, then busy fall. It sits between the requesters and the UART TX engine inside j1soc.

Parameters:
BUSY_WAIT_MAX, 15, cycles allowed between tx_start_o and tx_busy_i rising before the byte is declared dropped (range 1..255)
TIMEOUT_CYCLES, 1024, idle cycles a locked packet may stall before forced release (used only with the optional feature)

Ports:
sys_clk_i  in  1  system clock, all logic on the rising edge
sys_rst_i  in  1  asynchronous, active-low reset
req_valid_i  in  2  per-requester byte valid, bit n = requester n
req_data_i  in  16  bytes, [7:0] = req0, [15:8] = req1
req_last_i  in  2  byte is the last byte of its packet; qualified by the matching valid
req_ready_o  out  2  one-cycle accept pulse; the byte is consumed when valid and ready are both high
tx_start_o  out  1  one-cycle start strobe to the UART TX engine
tx_data_o  out  8  byte to transmit, held stable from the start strobe until busy falls
tx_busy_i  in  1  UART TX engine busy
grant_o  out  2  one-hot current owner, 00 when idle
active_o  out  1  packet in progress
drop_o  out  1  one-cycle pulse, no busy response within BUSY_WAIT_MAX
abort_o  out  1  one-cycle pulse, locked packet force-released (optional feature only; otherwise tied 0)

Behaviour:
- Reset (sys_rst_i low, asynchronous): state IDLE. All outputs 0. rr_ptr = 0, meaning req0 is preferred first. Reset mid-byte drops the byte and does not wait for the UART.
- States: IDLE, START, WAIT_RISE, WAIT_FALL, HOLD.
- IDLE:
  - If any valid is high, pick the winner: the only requester asserting, or on a tie the requester equal to rr_ptr.
  - In the same cycle: pulse req_ready_o[w], latch the data byte into tx_data_o, set grant_o, set active_o, go to START.
- START: tx_start_o = 1 for exactly one cycle; clear the wait counter; go to WAIT_RISE.
- WAIT_RISE:
  - tx_busy_i = 1: go to WAIT_FALL.
  - Counter reaches BUSY_WAIT_MAX: pulse drop_o, then treat the byte as done (apply the done rule below).
  - Count begins the cycle after tx_start_o.
- WAIT_FALL: on tx_busy_i = 0, the byte is done.
- Done rule:
  - If the latched last flag is 1: clear grant_o and active_o, set rr_ptr = other requester, go to IDLE.
  - Otherwise go to HOLD.
- HOLD (packet lock): the other requester is ignored.
  - If the owner's valid is high: pulse its ready, latch data and last, go to START.
  - Otherwise stay in HOLD.
- Latency:
  - Valid to ready is 0 cycles in IDLE.
  - Ready to tx_start_o is 1 cycle.
  - Busy fall to next ready (HOLD with valid already high) is 1 cycle.
- Single-byte packet: last = 1 on the first byte; no HOLD state is entered.
- A requester must hold data stable while valid is high and not yet readied; the arbiter never pulses both ready bits in one cycle.
- tx_busy_i already high on entry to WAIT_RISE is accepted as the rise.
- Throughput is at most one byte in flight; no internal FIFO.

Optional Feature:
J1_UART_ARB_TIMEOUT_EN
- Defined:
  - In HOLD, a counter increments on each cycle the owner's valid is low and clears when it is high.
  - When the counter reaches TIMEOUT_CYCLES: pulse abort_o, release the grant, set rr_ptr = other requester, go to IDLE.
- Not defined: HOLD waits indefinitely, abort_o is constant 0, and no counter is synthesized.

Test Plan:
- Single byte: req0 valid with 0x41 and last = 1 → ready[0] same cycle; tx_start_o next cycle with tx_data_o = 0x41; after busy high 10 cycles then low → grant_o = 00 and active_o = 0.
- Tie: both valid with single-byte packets 0x30 and 0x31, repeated three times after reset → send order 0x30, 0x31, 0x30, 0x31, 0x30, 0x31.
- Lock: req0 sends a 3-byte packet 0xA0/0xA1/0xA2 while req1 is valid from cycle 0 → req1 byte is sent only after 0xA2's busy falls; req1 sees no ready while grant_o = 01.
- Busy never rises: tx_busy_i held 0 → drop_o pulses 16 cycles after tx_start_o (BUSY_WAIT_MAX = 15 plus 1) and the single-byte packet completes to IDLE.
- Reset mid-byte: assert sys_rst_i low during WAIT_FALL → all outputs 0 immediately; after release, req1 single byte wins with rr_ptr = 0 only if req0 is idle.
- With J1_UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: req0 drops valid mid-packet → abort_o pulses after 8 idle HOLD cycles and a waiting req1 is granted the following cycle.
